fadd_pipe: RTL

- Three-stage pipelined IEEE-754 single-precision adder/subtractor with valid/ready handshakes on both sides.
- It is the counterpart to the single-cycle fsub in the FPU. One unit serves both FADD and FSUB, selected by a per-request op bit.
- It sits between the FPU issue logic and the FP writeback path. It accepts one operation per cycle when not stalled.

---
 rtl/fpu_pkg.sv | 47 ++++
 rtl/fpu_lzc.sv | 18 +
 rtl/fadd_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU widths, opcodes and stage payload types for the pipelined adder.
package fpu_pkg;

    localparam int WORD_W      = 32;
    localparam int EXP_W       = 8;
    localparam int FRAC_W      = 23;
    localparam int MAG_W       = 27;
    localparam int SHIFT_CLAMP = 31;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam logic FOP_ADD = 1'b0;
    localparam logic FOP_SUB = 1'b1;

    // Aligned operands: A is the larger magnitude, B is already shifted.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             eff_sub;
        logic [MAG_W-1:0] mag_a;
        logic [MAG_W-1:0] mag_b;
    } fadd_s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAG_W-1:0] sum;
    } fadd_s2_t;

    typedef struct packed {
        logic [WORD_W-1:0] y;
    } fadd_s3_t;

    // Zero/denormal inputs behave as exponent 1 with an empty mantissa.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    // Magnitude layout: carry, hidden one, fraction, two guard bits.
    function automatic logic [MAG_W-1:0] to_mag(input logic [EXP_W-1:0] e,
                                                input logic [FRAC_W-1:0] f);
        if (e == '0)
            return '0;
        return {1'b0, 1'b1, f, 2'b00};
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational 27-bit leading-zero counter; an all-zero input reports 27.
module fpu_lzc
    import fpu_pkg::*;
(
    input  logic [MAG_W-1:0] d,
    output logic [4:0]       cnt
);

    always_comb begin
        cnt = 5'(MAG_W);
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < MAG_W; i++) begin
            if (d[i])
                cnt = 5'(MAG_W - 1 - i);
        end
    end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage single-precision add/subtract with a globally stalled pipe.
// Define FADD_PIPE_OVF_EN to get a registered overflow flag on ovf.
module fadd_pipe
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [WORD_W-1:0] x1,
    input  logic [WORD_W-1:0] x2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] y,
    output logic              ovf
);

    logic     v1_reg, v2_reg, v3_reg;
    fadd_s1_t s1_reg, s1_next;
    fadd_s2_t s2_reg, s2_next;
    fadd_s3_t s3_reg, s3_next;
    logic     advance;

    assign advance   = !v3_reg || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_reg;
    assign y         = s3_reg.y;

    // Stage 1: sign fix-up, magnitude ordering and alignment shift.
    logic             sign_b_in;
    logic [EXP_W-1:0] exp1, exp2, exp_diff;
    logic [MAG_W-1:0] mag1, mag2, mag_small;
    logic             swap;
    logic [4:0]       shamt;

    always_comb begin
        sign_b_in = x2[31] ^ (in_op == FOP_SUB);
        exp1      = eff_exp(x1[30:23]);
        exp2      = eff_exp(x2[30:23]);
        mag1      = to_mag(x1[30:23], x1[22:0]);
        mag2      = to_mag(x2[30:23], x2[22:0]);
        swap      = {exp2, mag2} > {exp1, mag1};
        s1_next   = '0;
        s1_next.eff_sub = x1[31] ^ sign_b_in;
        if (swap) begin
            s1_next.sign  = sign_b_in;
            s1_next.exp   = exp2;
            s1_next.mag_a = mag2;
            mag_small     = mag1;
            exp_diff      = exp2 - exp1;
        end else begin
            s1_next.sign  = x1[31];
            s1_next.exp   = exp1;
            s1_next.mag_a = mag1;
            mag_small     = mag2;
            exp_diff      = exp1 - exp2;
        end
        shamt = (exp_diff > EXP_W'(SHIFT_CLAMP)) ? 5'(SHIFT_CLAMP) : exp_diff[4:0];
        s1_next.mag_b = mag_small >> shamt;
    end

    always_comb begin
        s2_next      = '0;
        s2_next.sign = s1_reg.sign;
        s2_next.exp  = s1_reg.exp;
        s2_next.sum  = s1_reg.eff_sub ? (s1_reg.mag_a - s1_reg.mag_b)
                                      : (s1_reg.mag_a + s1_reg.mag_b);
    end

    // Stage 3: normalise, detect overflow/underflow, truncate guard bits.
    logic [4:0]       lzc;
    logic [EXP_W:0]   exp_inc;
    logic [EXP_W-1:0] exp_norm;
    logic [FRAC_W-1:0] frac_carry, frac_norm;
`ifdef FADD_PIPE_OVF_EN
    logic             ovf_next;
    logic             ovf_reg;
`endif

    fpu_lzc u_lzc (
        .d   (s2_reg.sum),
        .cnt (lzc)
    );

    always_comb begin
        s3_next    = '0;
`ifdef FADD_PIPE_OVF_EN
        ovf_next   = 1'b0;
`endif
        exp_inc    = {1'b0, s2_reg.exp} + (EXP_W+1)'(1);
        exp_norm   = s2_reg.exp + EXP_W'(1) - {3'b000, lzc};
        frac_carry = FRAC_W'(s2_reg.sum >> 3);
        frac_norm  = FRAC_W'((s2_reg.sum << lzc) >> 3);
        if (s2_reg.sum == '0) begin
            s3_next.y = '0;
        end else if (s2_reg.sum[MAG_W-1]) begin
            if (exp_inc == {1'b0, EXP_MAX}) begin
                s3_next.y = {s2_reg.sign, EXP_MAX, {FRAC_W{1'b0}}};
`ifdef FADD_PIPE_OVF_EN
                ovf_next  = 1'b1;
`endif
            end else begin
                s3_next.y = {s2_reg.sign, exp_inc[EXP_W-1:0], frac_carry};
            end
        end else if ({3'b000, lzc} >= s2_reg.exp) begin
            s3_next.y = {s2_reg.sign, {(WORD_W-1){1'b0}}};
        end else begin
            s3_next.y = {s2_reg.sign, exp_norm, frac_norm};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else if (advance) begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
            s1_reg <= s1_next;
            s2_reg <= s2_next;
            s3_reg <= s3_next;
        end
    end

`ifdef FADD_PIPE_OVF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ovf_reg <= 1'b0;
        else if (advance)
            ovf_reg <= ovf_next;
    end
    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule
